// File: rtl/cram_pkg.sv
// Shared types and default timing for the CellularRAM asynchronous write engine.
package cram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } cram_state_e;

  localparam int unsigned CRAM_ADDR_W     = 26;
  localparam int unsigned DEFAULT_T_SETUP = 1;
  localparam int unsigned DEFAULT_T_WE    = 7;
  localparam int unsigned DEFAULT_T_HOLD  = 1;

endpackage

// File: rtl/cellular_ram_writer.sv
// Asynchronous-mode CellularRAM write engine: one 16-bit word per request,
// sequencing CE/WE/UB/LB with programmable setup, WE pulse and hold lengths.
module cellular_ram_writer
  import cram_pkg::*;
#(
  parameter int unsigned ADDR_W  = CRAM_ADDR_W,
  parameter int unsigned T_SETUP = DEFAULT_T_SETUP,
  parameter int unsigned T_WE    = DEFAULT_T_WE,
  parameter int unsigned T_HOLD  = DEFAULT_T_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic [15:0]       DQ_out,
  output logic              DQ_oe,
  output logic              CE,
  output logic              WE,
  output logic              OE,
  output logic              UB,
  output logic              LB,
  output logic              ADV,
  output logic              CRE,
  output logic              CLK
);

  localparam logic [3:0] SetupCnt = 4'(T_SETUP - 1);
  localparam logic [3:0] WeCnt    = 4'(T_WE - 1);
  localparam logic [3:0] HoldCnt  = 4'(T_HOLD - 1);

  cram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        be_q, be_d;
  logic              done_d;

  logic ce_q, we_q, ub_q, lb_q, oe_drv_q, ready_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = SETUP;
          cnt_d   = SetupCnt;
          addr_d  = wr_addr;
          data_d  = wr_data;
          be_d    = wr_be;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = PULSE;
          cnt_d   = WeCnt;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HoldCnt;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // Strobes are registered from the next state so every pin changes on a clock edge
  // and lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= 2'b00;
      ce_q     <= 1'b1;
      we_q     <= 1'b1;
      ub_q     <= 1'b1;
      lb_q     <= 1'b1;
      oe_drv_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      ce_q     <= (state_d == IDLE);
      we_q     <= (state_d != PULSE);
      ub_q     <= (state_d == IDLE) | ~be_d[1];
      lb_q     <= (state_d == IDLE) | ~be_d[0];
      oe_drv_q <= (state_d != IDLE);
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
    end
  end

  assign wr_ready = ready_q;
  assign busy     = busy_q;
  assign wr_done  = done_q;
  assign A        = addr_q;
  assign DQ_out   = data_q;
  assign DQ_oe    = oe_drv_q;
  assign CE       = ce_q;
  assign WE       = we_q;
  assign UB       = ub_q;
  assign LB       = lb_q;
  assign OE       = 1'b1;
  assign ADV      = 1'b0;
  assign CRE      = 1'b0;
  assign CLK      = 1'b0;

endmodule

// File: tb/tb_cellular_ram_writer.sv
// Directed bench for cellular_ram_writer: default timing instance plus a
// T_SETUP=2/T_WE=3/T_HOLD=2 instance, sampled on the falling clock edge.
module tb_cellular_ram_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Default-timing instance
  logic        req0 = 1'b0, rdy0, done0, busy0;
  logic [25:0] addr0 = '0, a0;
  logic [15:0] data0 = '0, dq0;
  logic [1:0]  be0 = 2'b11;
  logic        oe_drv0, ce0, we0, oe0, ub0, lb0, adv0, cre0, clk0;

  // Parameter-sweep instance
  logic        req1 = 1'b0, rdy1, done1, busy1;
  logic [25:0] addr1 = '0, a1;
  logic [15:0] data1 = '0, dq1;
  logic [1:0]  be1 = 2'b11;
  logic        oe_drv1, ce1, we1, oe1, ub1, lb1, adv1, cre1, clk1;

  cellular_ram_writer dut0 (
    .clk(clk), .rst(rst), .wr_req(req0), .wr_ready(rdy0), .wr_addr(addr0),
    .wr_data(data0), .wr_be(be0), .wr_done(done0), .busy(busy0), .A(a0),
    .DQ_out(dq0), .DQ_oe(oe_drv0), .CE(ce0), .WE(we0), .OE(oe0), .UB(ub0),
    .LB(lb0), .ADV(adv0), .CRE(cre0), .CLK(clk0)
  );

  cellular_ram_writer #(.T_SETUP(2), .T_WE(3), .T_HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .wr_req(req1), .wr_ready(rdy1), .wr_addr(addr1),
    .wr_data(data1), .wr_be(be1), .wr_done(done1), .busy(busy1), .A(a1),
    .DQ_out(dq1), .DQ_oe(oe_drv1), .CE(ce1), .WE(we1), .OE(oe1), .UB(ub1),
    .LB(lb1), .ADV(adv1), .CRE(cre1), .CLK(clk1)
  );

  // Trace statistics filled by capture; index 0 is the cycle right after acceptance.
  int ce_low_n, ce_first, ce_last, we_low_n, we_first, we_last;
  int done_n, done_idx, ub_low_n, lb_low_n;
  bit data_ok, rdy_ok;

  task automatic capture(input int which, input int n, input logic [25:0] exp_a,
                         input logic [15:0] exp_d);
    logic c, w, d, u, l, oe, r, b;
    logic [25:0] a;
    logic [15:0] q;
    ce_low_n = 0; ce_first = -1; ce_last = -1;
    we_low_n = 0; we_first = -1; we_last = -1;
    done_n = 0; done_idx = -1; ub_low_n = 0; lb_low_n = 0;
    data_ok = 1'b1; rdy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 0) begin
        c = ce0; w = we0; d = done0; u = ub0; l = lb0; oe = oe_drv0; r = rdy0; b = busy0;
        a = a0; q = dq0;
      end else begin
        c = ce1; w = we1; d = done1; u = ub1; l = lb1; oe = oe_drv1; r = rdy1; b = busy1;
        a = a1; q = dq1;
      end
      if (c === 1'b0) begin
        ce_low_n++;
        if (ce_first < 0) ce_first = i;
        ce_last = i;
        if (oe !== 1'b1 || a !== exp_a || q !== exp_d) data_ok = 1'b0;
      end
      if (w === 1'b0) begin
        we_low_n++;
        if (we_first < 0) we_first = i;
        we_last = i;
      end
      if (d === 1'b1) begin
        done_n++;
        if (done_idx < 0) done_idx = i;
      end
      if (u === 1'b0 && c === 1'b0) ub_low_n++;
      if (l === 1'b0 && c === 1'b0) lb_low_n++;
      if (r !== c || b !== ~c) rdy_ok = 1'b0;
    end
  endtask

  task automatic issue0(input logic [25:0] ad, input logic [15:0] dt, input logic [1:0] be);
    @(negedge clk);
    req0 = 1'b1; addr0 = ad; data0 = dt; be0 = be;
    @(posedge clk);
    #1;
    req0 = 1'b0; addr0 = 26'h3FFFFFF; data0 = 16'h5555; be0 = 2'b01;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({rdy0, busy0, done0, ce0, we0, oe0, ub0, lb0, oe_drv0, adv0, cre0, clk0}
        !== 12'b100_11111_0000)
      $display("FAIL reset_strobes: got %b want 100111110000",
               {rdy0, busy0, done0, ce0, we0, oe0, ub0, lb0, oe_drv0, adv0, cre0, clk0});
    else pass_cnt++;
    total_cnt++;
    if (a0 !== 26'h0 || dq0 !== 16'h0)
      $display("FAIL reset_bus: got A=%h DQ=%h want 0/0", a0, dq0);
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    issue0(26'h0001234, 16'hBEEF, 2'b11);
    capture(0, 12, 26'h0001234, 16'hBEEF);
    total_cnt++;
    if (ce_low_n != 9 || ce_first != 0)
      $display("FAIL single_ce: got len=%0d first=%0d want 9/0", ce_low_n, ce_first);
    else pass_cnt++;
    total_cnt++;
    if (we_low_n != 7 || we_first != 1)
      $display("FAIL single_we: got len=%0d first=%0d want 7/1", we_low_n, we_first);
    else pass_cnt++;
    total_cnt++;
    if (done_n != 1 || done_idx != 9)
      $display("FAIL single_done: got n=%0d idx=%0d want 1/9", done_n, done_idx);
    else pass_cnt++;
    total_cnt++;
    if (!data_ok) $display("FAIL single_bus: got bad A/DQ/DQ_oe want 0001234/BEEF/1");
    else pass_cnt++;
    total_cnt++;
    if (!rdy_ok || ub_low_n != 9 || lb_low_n != 9)
      $display("FAIL single_ready_lanes: got rdy_ok=%0d ub=%0d lb=%0d want 1/9/9",
               rdy_ok, ub_low_n, lb_low_n);
    else pass_cnt++;
    total_cnt++;
    if (oe0 !== 1'b1) $display("FAIL single_oe: got %b want 1", oe0);
    else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    issue0(26'h0000042, 16'h1234, 2'b10);
    capture(0, 12, 26'h0000042, 16'h1234);
    total_cnt++;
    if (ub_low_n != 9 || lb_low_n != 0)
      $display("FAIL lane_upper: got ub=%0d lb=%0d want 9/0", ub_low_n, lb_low_n);
    else pass_cnt++;
    issue0(26'h0000043, 16'h5678, 2'b00);
    capture(0, 12, 26'h0000043, 16'h5678);
    total_cnt++;
    if (ub_low_n != 0 || lb_low_n != 0)
      $display("FAIL lane_none: got ub=%0d lb=%0d want 0/0", ub_low_n, lb_low_n);
    else pass_cnt++;
    total_cnt++;
    if (ce_low_n != 9 || we_low_n != 7 || done_n != 1 || done_idx != 9)
      $display("FAIL lane_none_cycle: got ce=%0d we=%0d done=%0d@%0d want 9/7/1@9",
               ce_low_n, we_low_n, done_n, done_idx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req0 = 1'b1; addr0 = 26'h00000A1; data0 = 16'h00A1; be0 = 2'b11;
    @(posedge clk);
    #1;
    addr0 = 26'h00000A2; data0 = 16'h00A2;
    capture(0, 10, 26'h00000A1, 16'h00A1);
    total_cnt++;
    if (ce_low_n != 9 || done_idx != 9 || !data_ok || !rdy_ok)
      $display("FAIL b2b_first: got ce=%0d done@%0d data_ok=%0d rdy_ok=%0d want 9/9/1/1",
               ce_low_n, done_idx, data_ok, rdy_ok);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    capture(0, 12, 26'h00000A2, 16'h00A2);
    total_cnt++;
    if (ce_first != 0 || ce_low_n != 9 || !data_ok)
      $display("FAIL b2b_second: got first=%0d ce=%0d data_ok=%0d want 0/9/1",
               ce_first, ce_low_n, data_ok);
    else pass_cnt++;
    total_cnt++;
    if (done_n != 1 || done_idx != 9 || ce_last != 8)
      $display("FAIL b2b_count: got done=%0d@%0d ce_last=%0d want 1@9/8",
               done_n, done_idx, ce_last);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    issue0(26'h0000777, 16'hC0DE, 2'b11);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (we0 !== 1'b0) $display("FAIL midrst_pre: got WE=%b want 0", we0);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ce0, we0, oe_drv0, rdy0, busy0} !== 5'b11010)
      $display("FAIL midrst_async: got %b want 11010", {ce0, we0, oe_drv0, rdy0, busy0});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    capture(0, 12, 26'h0, 16'h0);
    total_cnt++;
    if (done_n != 0 || ce_low_n != 0 || !rdy_ok || a0 !== 26'h0)
      $display("FAIL midrst_after: got done=%0d ce=%0d rdy_ok=%0d A=%h want 0/0/1/0",
               done_n, ce_low_n, rdy_ok, a0);
    else pass_cnt++;
  endtask

  task automatic test_param_sweep();
    @(negedge clk);
    req1 = 1'b1; addr1 = 26'h2ABCDEF; data1 = 16'h9A5C; be1 = 2'b01;
    @(posedge clk);
    #1;
    req1 = 1'b0; data1 = 16'h0000;
    capture(1, 12, 26'h2ABCDEF, 16'h9A5C);
    total_cnt++;
    if (ce_low_n != 7 || ce_first != 0 || ce_last != 6)
      $display("FAIL sweep_ce: got len=%0d first=%0d last=%0d want 7/0/6",
               ce_low_n, ce_first, ce_last);
    else pass_cnt++;
    total_cnt++;
    if (we_low_n != 3 || we_first != 2 || we_last != 4)
      $display("FAIL sweep_we: got len=%0d first=%0d last=%0d want 3/2/4",
               we_low_n, we_first, we_last);
    else pass_cnt++;
    total_cnt++;
    if (done_n != 1 || done_idx != 7 || !data_ok || ub_low_n != 0 || lb_low_n != 7)
      $display("FAIL sweep_done: got done=%0d@%0d data_ok=%0d ub=%0d lb=%0d want 1@7/1/0/7",
               done_n, done_idx, data_ok, ub_low_n, lb_low_n);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_byte_lanes();
    test_back_to_back();
    test_reset_mid_pulse();
    test_param_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
